regfile_port_arbiter: RTL and testbench

//  Shares the single-port 16x16 register file between NUM_REQ requesters (ALU writeback, load unit, debug, ...).

---
 rtl/regfile_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// ============================================================================
// regfile_port_arbiter: round-robin sharing of one 16x16 register file port
// among NUM_REQ requesters. Optional macro RF_ARB_WPROT_EN write-protects addr 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rf_write_enable,
    output logic [ADDR_W-1:0]         rf_write_address,
    output logic [ADDR_W-1:0]         rf_read_address,
    output logic [DATA_W-1:0]         rf_data_in,
    input  logic [DATA_W-1:0]         rf_data_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [PTR_W:0]       NUM_REQ_P = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0]     LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   ONE_HOT0  = NUM_REQ'(1);

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   win_q;
    logic               write_q;
    logic               blocked_q;
    logic [NUM_REQ-1:0] ready_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  din_q;

    logic [PTR_W:0]     cand;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_found;
    logic               grant_write;
    logic               grant_blocked;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_wdata;

    // Scan from rr_ptr upward with wrap; the first requester found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= NUM_REQ_P) begin
                cand = cand - NUM_REQ_P;
            end
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign grant_write = req_write[grant_idx];
    assign grant_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign grant_wdata = req_wdata[grant_idx*DATA_W +: DATA_W];

`ifdef RF_ARB_WPROT_EN
    assign grant_blocked = grant_write && (grant_addr == '0);
`else
    assign grant_blocked = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = ACCESS;
            ACCESS: begin
                state_d  = RESP;
                rr_ptr_d = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is a flop; pulses default low and are set only in their phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            write_q     <= 1'b0;
            blocked_q   <= 1'b0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        win_q     <= grant_idx;
                        write_q   <= grant_write;
                        blocked_q <= grant_blocked;
                        ready_q   <= ONE_HOT0 << grant_idx;
                        we_q      <= grant_write && !grant_blocked;
                        addr_q    <= grant_addr;
                        din_q     <= grant_write ? grant_wdata : '0;
                    end
                end
                ACCESS: begin
                    rsp_valid_q <= ONE_HOT0 << win_q;
                    rdata_q     <= write_q ? '0 : rf_data_out;
                    err_q       <= blocked_q;
                end
                default: ;
            endcase
        end
    end

    assign req_ready        = ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rdata_q;
    assign rsp_err          = err_q;
    assign rf_write_enable  = we_q;
    assign rf_write_address = addr_q;
    assign rf_read_address  = addr_q;
    assign rf_data_in       = din_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
// ============================================================================
// tb_regfile_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbiter and register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 16;
`ifdef RF_ARB_WPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            rf_write_enable;
    logic [AW-1:0]   rf_write_address, rf_read_address;
    logic [DW-1:0]   rf_data_in, rf_data_out;

    regfile_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .rf_write_enable  (rf_write_enable),
        .rf_write_address (rf_write_address),
        .rf_read_address  (rf_read_address),
        .rf_data_in       (rf_data_in),
        .rf_data_out      (rf_data_out)
    );

    always #5 clk = ~clk;

    // Register file itself: combinational read, synchronous write.
    logic [DW-1:0] rf_mem [16];
    assign rf_data_out = rf_mem[rf_read_address];
    always @(posedge clk) begin
        if (rf_write_enable === 1'b1) rf_mem[rf_write_address] <= rf_data_in;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Requester-side pending requests and refill policy: 0 drop, 1 keep, 2 random.
    logic [N-1:0]  pv, pw, refill;
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    int            mode;

    // Reference model state (transaction level).
    logic [DW-1:0] gold [16];
    int            busy, ptr, cyc;
    int            g_idx;
    bit            g_w, g_blk;
    logic [AW-1:0] g_a;
    logic [DW-1:0] g_d;
    int            gq_idx[$], gq_cyc[$], rc_cyc[$];
    logic [DW-1:0] rq_data[$];
    logic          rq_err[$];

    int e3 [5] = '{0, 1, 2, 3, 0};
    int e4 [3] = '{0, 2, 0};

    function automatic bit wr_blocked(bit w, logic [AW-1:0] a);
        return PROT && w && (a == '0);
    endfunction

    // Winner = valid requester with the smallest forward distance from the pointer.
    function automatic int pick(logic [N-1:0] v, int p);
        int best, bd, d;
        best = -1;
        bd   = N;
        for (int j = 0; j < N; j++) begin
            d = (j - p + N) % N;
            if (v[j] && d < bd) begin
                bd   = d;
                best = j;
            end
        end
        return best;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = pv[i];
            req_write[i]            = pw[i];
            req_addr[i*AW +: AW]    = pa[i];
            req_wdata[i*DW +: DW]   = pd[i];
        end
    endtask

    task automatic new_random(input int i);
        pv[i] = 1'b1;
        pw[i] = 1'($urandom % 2);
        pa[i] = ($urandom % 5 == 0) ? '0 : AW'($urandom % 16);
        pd[i] = DW'($urandom);
    endtask

    task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pv[i] = 1'b1; pw[i] = w; pa[i] = a; pd[i] = d;
        drive();
    endtask

    task automatic model_reset();
        busy = 0; ptr = 0;
        pv = '0; pw = '0; refill = '0;
        for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; end
        drive();
    endtask

    task automatic clear_logs();
        gq_idx.delete(); gq_cyc.delete(); rc_cyc.delete(); rq_data.delete(); rq_err.delete();
    endtask

    task automatic step();
        logic [N-1:0]    sv, sw, exp_ready, exp_rsp;
        logic [N*AW-1:0] sa;
        logic [N*DW-1:0] sd;
        logic            exp_we;
        logic [DW-1:0]   exp_rd;
        sv = req_valid; sw = req_write; sa = req_addr; sd = req_wdata;
        exp_ready = '0; exp_rsp = '0; exp_we = 1'b0; exp_rd = '0;
        @(posedge clk);
        #1;
        cyc++;
        if (busy == 0) begin
            if (sv != '0) begin
                g_idx = pick(sv, ptr);
                g_w   = sw[g_idx];
                g_a   = sa[g_idx*AW +: AW];
                g_d   = sd[g_idx*DW +: DW];
                g_blk = wr_blocked(g_w, g_a);
                busy  = 2;
                exp_ready[g_idx] = 1'b1;
                exp_we = g_w && !g_blk;
                gq_idx.push_back(g_idx);
                gq_cyc.push_back(cyc);
            end
        end else begin
            busy--;
            if (busy == 1) begin
                exp_rsp[g_idx] = 1'b1;
                if (g_w) begin
                    if (!g_blk) gold[g_a] = g_d;
                end else begin
                    exp_rd = gold[g_a];
                end
                ptr = (g_idx + 1) % N;
            end
        end
        check_value("req_ready", 32'(req_ready), 32'(exp_ready));
        check_value("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        check_value("rf_we", 32'(rf_write_enable), 32'(exp_we));
        if (exp_ready != '0) begin
            check_value("rf_waddr", 32'(rf_write_address), 32'(g_a));
            check_value("rf_raddr", 32'(rf_read_address), 32'(g_a));
            if (exp_we) check_value("rf_din", 32'(rf_data_in), 32'(g_d));
        end
        if (exp_rsp != '0) begin
            check_value("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
            check_value("rsp_err", 32'(rsp_err), 32'(g_blk));
        end
        if (rsp_valid != '0) begin
            rc_cyc.push_back(cyc);
            rq_data.push_back(rsp_rdata);
            rq_err.push_back(rsp_err);
        end
        // Requesters act on a grant from the cycle after req_ready.
        for (int i = 0; i < N; i++) begin
            if (refill[i]) begin
                refill[i] = 1'b0;
                if (mode == 0) pv[i] = 1'b0;
                else if (mode == 2) begin
                    if ($urandom % 4 == 0) pv[i] = 1'b0;
                    else new_random(i);
                end
            end else if (mode == 2 && !pv[i] && ($urandom % 3 == 0)) begin
                new_random(i);
            end
            if (req_ready[i] === 1'b1) refill[i] = 1'b1;
        end
        drive();
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    int start;

    initial begin
        for (int i = 0; i < 16; i++) begin rf_mem[i] = '0; gold[i] = '0; end
        cyc = 0; mode = 0;
        model_reset();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_ready", 32'(req_ready), 32'h0);
        check_value("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_value("rst_rdata", 32'(rsp_rdata), 32'h0);
        check_value("rst_err", 32'(rsp_err), 32'h0);
        check_value("rst_we", 32'(rf_write_enable), 32'h0);
        check_value("rst_addr", 32'({rf_write_address, rf_read_address}), 32'h0);
        check_value("rst_din", 32'(rf_data_in), 32'h0);
        reset = 1'b1;

        // Write then read, single requester.
        clear_logs(); mode = 0;
        set_req(0, 1'b1, 4'd5, 16'hBEEF);
        start = cyc;
        run(4);
        set_req(0, 1'b0, 4'd5, 16'h0);
        run(4);
        check_value("t2_grants", gq_idx.size(), 2);
        if (gq_cyc.size() == 2) check_value("t2_ready_cyc", gq_cyc[0] - start, 1);
        if (rc_cyc.size() == 2) check_value("t2_rsp_cyc", rc_cyc[0] - start, 2);
        if (rq_data.size() == 2) check_value("t2_readback", 32'(rq_data[1]), 32'hBEEF);

        // Round robin with all four held continuously.
        apply_reset(); clear_logs(); mode = 1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i + 1), 16'h0);
        run(15);
        check_value("t3_grants", gq_idx.size(), 5);
        if (gq_idx.size() == 5) begin
            for (int k = 0; k < 5; k++) check_value("t3_order", gq_idx[k], e3[k]);
            for (int k = 0; k < 4; k++) check_value("t3_gap", gq_cyc[k+1] - gq_cyc[k], 3);
        end
        mode = 0;
        run(16);

        // Wrap and skip from rr_ptr = 3.
        apply_reset(); mode = 0;
        set_req(2, 1'b0, 4'd1, 16'h0);
        run(4);
        clear_logs(); mode = 1;
        set_req(0, 1'b0, 4'd2, 16'h0);
        set_req(2, 1'b0, 4'd3, 16'h0);
        run(9);
        check_value("t4_grants", gq_idx.size(), 3);
        if (gq_idx.size() == 3)
            for (int k = 0; k < 3; k++) check_value("t4_order", gq_idx[k], e4[k]);
        mode = 0;
        run(12);

        // Contention: write then read of the same address from rr_ptr = 1.
        apply_reset(); mode = 0;
        set_req(0, 1'b0, 4'd3, 16'h0);
        run(4);
        clear_logs();
        set_req(1, 1'b1, 4'd9, 16'h1234);
        set_req(2, 1'b0, 4'd9, 16'h0);
        run(8);
        check_value("t5_grants", gq_idx.size(), 2);
        if (gq_idx.size() == 2) begin
            check_value("t5_first", gq_idx[0], 1);
            check_value("t5_second", gq_idx[1], 2);
        end
        if (rq_data.size() == 2) check_value("t5_readback", 32'(rq_data[1]), 32'h1234);

        // Reset in the middle of a write access.
        clear_logs();
        set_req(1, 1'b1, 4'd7, 16'hABCD);
        step();
        check_value("t1_in_access", 32'(req_ready), 32'h2);
        reset = 1'b0;
        #1;
        check_value("t1_ready0", 32'(req_ready), 32'h0);
        check_value("t1_we0", 32'(rf_write_enable), 32'h0);
        check_value("t1_addr0", 32'({rf_write_address, rf_data_in}), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_value("t1_no_rsp", 32'(rsp_valid), 32'h0);
        reset = 1'b1;
        clear_logs();
        set_req(2, 1'b0, 4'd7, 16'h0);
        set_req(3, 1'b0, 4'd7, 16'h0);
        run(8);
        if (gq_idx.size() >= 1) check_value("t1_ptr0", gq_idx[0], 2);
        else check_value("t1_grants", gq_idx.size(), 1);
        if (rq_data.size() >= 1) check_value("t1_aborted", 32'(rq_data[0]), 32'h0);

        // Address 0 write (protected when RF_ARB_WPROT_EN is defined).
        clear_logs();
        set_req(0, 1'b1, 4'd0, 16'hFFFF);
        run(4);
        set_req(0, 1'b0, 4'd0, 16'h0);
        run(4);
        check_value("t6_rsps", rq_data.size(), 2);
        if (rq_data.size() == 2) begin
            check_value("t6_err", 32'(rq_err[0]), 32'(PROT));
            check_value("t6_read_err", 32'(rq_err[1]), 32'h0);
            check_value("t6_readback", 32'(rq_data[1]), PROT ? 32'h0 : 32'hFFFF);
        end

        // Randomized traffic, then drain.
        mode = 2;
        run(400);
        mode = 0;
        run(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
